// File: rtl/pipe_pkg.sv
// Shared pipeline widths, bubble constants and the ID/EX per-edge action selector.
// The action priority lives here so every stage resolves hold/flush/hazard the same way.
package pipe_pkg;

  localparam int XLEN      = 32;
  localparam int ALUOP_W   = 4;
  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic valid;
    logic write_reg;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE_CTRL = '{
    valid:     1'b0,
    write_reg: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    branch:    1'b0
  };

  typedef enum logic [1:0] {
    ACT_ADVANCE  = 2'd0,
    ACT_LOAD_USE = 2'd1,
    ACT_FLUSH    = 2'd2,
    ACT_HOLD     = 2'd3
  } ex_action_t;

  // A memory stall freezes everything, so a flush or hazard seen during it is re-evaluated later.
  function automatic ex_action_t select_action(input logic stall,
                                               input logic flush,
                                               input logic hazard);
    if (stall) begin
      return ACT_HOLD;
    end
    if (flush) begin
      return ACT_FLUSH;
    end
    if (hazard) begin
      return ACT_LOAD_USE;
    end
    return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: the load in EX writes a register the ID instruction reads.
// Purely combinational, zero latency; x0 is never a hazard since it is hard-wired to zero.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic                 ex_valid,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 id_valid,
  input  logic                 id_use_rs1,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] id_rs2,
  output logic                 load_use
);

  logic rs1_hit;
  logic rs2_hit;
  logic ex_is_load;

  assign ex_is_load = ex_valid & ex_mem_read & (ex_rd != REG_ZERO);
  assign rs1_hit    = id_use_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit    = id_use_rs2 & (id_rs2 == ex_rd);
  assign load_use   = ex_is_load & id_valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and memory-stall freeze; ID->EX 1 cycle.
// mem_stall holds EX and front end; optional event counters when ID_EX_PERF_EN is defined.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN    = pipe_pkg::XLEN,
  parameter int ALUOP_W = pipe_pkg::ALUOP_W
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 id_writeReg,
  input  logic                 id_memRead,
  input  logic                 id_memWrite,
  input  logic                 id_branch,
  input  logic [ALUOP_W-1:0]   id_aluOp,

  input  logic                 ex_flush,
  input  logic                 mem_stall,

  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_rs1_data,
  output logic [XLEN-1:0]      ex_rs2_data,
  output logic [XLEN-1:0]      ex_imm,
  output logic [REG_IDX_W-1:0] ex_rs1,
  output logic [REG_IDX_W-1:0] ex_rs2,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic                 ex_writeReg,
  output logic                 ex_memRead,
  output logic                 ex_memWrite,
  output logic                 ex_branch,
  output logic [ALUOP_W-1:0]   ex_aluOp,

  output logic                 pc_hold,
  output logic                 ifid_hold,
  output logic                 ifid_flush
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]          load_use_cnt,
  output logic [31:0]          flush_cnt
`endif
);

  ex_ctrl_t               ctrl_q,      ctrl_d;
  logic [XLEN-1:0]        pc_q,        pc_d;
  logic [XLEN-1:0]        rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0]        rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0]        imm_q,       imm_d;
  logic [REG_IDX_W-1:0]   rs1_q,       rs1_d;
  logic [REG_IDX_W-1:0]   rs2_q,       rs2_d;
  logic [REG_IDX_W-1:0]   rd_q,        rd_d;
  logic [ALUOP_W-1:0]     alu_op_q,    alu_op_d;

  logic       load_use;
  ex_action_t action;
  logic       front_stall;
  logic       front_flush;

  hazard_detect u_hazard_detect (
    .ex_valid    (ctrl_q.valid),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd       (rd_q),
    .id_valid    (id_valid),
    .id_use_rs1  (id_use_rs1),
    .id_rs1      (id_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rs2      (id_rs2),
    .load_use    (load_use)
  );

  assign action = select_action(mem_stall, ex_flush, load_use);

  // Next EX contents default to a bubble; only hold and a valid advance override that.
  always_comb begin
    ctrl_d      = BUBBLE_CTRL;
    pc_d        = '0;
    rs1_data_d  = '0;
    rs2_data_d  = '0;
    imm_d       = '0;
    rs1_d       = REG_ZERO;
    rs2_d       = REG_ZERO;
    rd_d        = REG_ZERO;
    alu_op_d    = '0;
    front_stall = 1'b0;
    front_flush = 1'b0;

    case (action)
      ACT_HOLD: begin
        ctrl_d      = ctrl_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        alu_op_d    = alu_op_q;
        front_stall = 1'b1;
      end
      ACT_FLUSH: begin
        front_flush = 1'b1;
      end
      ACT_LOAD_USE: begin
        front_stall = 1'b1;
      end
      default: begin
        if (id_valid) begin
          ctrl_d.valid     = 1'b1;
          ctrl_d.write_reg = id_writeReg;
          ctrl_d.mem_read  = id_memRead;
          ctrl_d.mem_write = id_memWrite;
          ctrl_d.branch    = id_branch;
          pc_d             = id_pc;
          rs1_data_d       = id_rs1_data;
          rs2_data_d       = id_rs2_data;
          imm_d            = id_imm;
          rs1_d            = id_rs1;
          rs2_d            = id_rs2;
          rd_d             = id_rd;
          alu_op_d         = id_aluOp;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= BUBBLE_CTRL;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= REG_ZERO;
      rs2_q      <= REG_ZERO;
      rd_q       <= REG_ZERO;
      alu_op_q   <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      alu_op_q   <= alu_op_d;
    end
  end

  // Front-end controls stay quiet while reset is asserted, even if mem_stall is high.
  assign pc_hold    = front_stall & rst_n;
  assign ifid_hold  = front_stall & rst_n;
  assign ifid_flush = front_flush & rst_n;

  assign ex_valid    = ctrl_q.valid;
  assign ex_writeReg = ctrl_q.write_reg;
  assign ex_memRead  = ctrl_q.mem_read;
  assign ex_memWrite = ctrl_q.mem_write;
  assign ex_branch   = ctrl_q.branch;
  assign ex_pc       = pc_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_imm      = imm_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_aluOp    = alu_op_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] load_use_cnt_q, load_use_cnt_d;
  logic [31:0] flush_cnt_q,    flush_cnt_d;

  always_comb begin
    load_use_cnt_d = load_use_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    if (action == ACT_LOAD_USE) begin
      load_use_cnt_d = load_use_cnt_q + 32'd1;
    end
    if (action == ACT_FLUSH) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_use_cnt_q <= '0;
      flush_cnt_q    <= '0;
    end else begin
      load_use_cnt_q <= load_use_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign load_use_cnt = load_use_cnt_q;
  assign flush_cnt    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table with hand-derived hold/flush expectations and an EX-payload scoreboard.
// Hand sequences cover reset state, asynchronous reset mid-stall and counters when ID_EX_PERF_EN is defined.
module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam int AW   = 4;
  localparam int NV   = 26;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            id_use_rs1, id_use_rs2;
  logic            id_writeReg, id_memRead, id_memWrite, id_branch;
  logic [AW-1:0]   id_aluOp;
  logic            ex_flush, mem_stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic            ex_writeReg, ex_memRead, ex_memWrite, ex_branch;
  logic [AW-1:0]   ex_aluOp;
  logic            pc_hold, ifid_hold, ifid_flush;
`ifdef ID_EX_PERF_EN
  logic [31:0]     load_use_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .ALUOP_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_writeReg(id_writeReg), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
    .id_branch(id_branch), .id_aluOp(id_aluOp),
    .ex_flush(ex_flush), .mem_stall(mem_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_writeReg(ex_writeReg), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_branch(ex_branch), .ex_aluOp(ex_aluOp),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush)
`ifdef ID_EX_PERF_EN
    , .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct packed {
    logic        vld;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        wr, mr, mw, br;
    logic [3:0]  op;
  } ex_t;

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        wr, mr, mw, br;
    logic [3:0]  op;
    logic        flush, stall;
    logic        e_hold, e_iff;
  } vec_t;

  vec_t tv[NV];
  ex_t  exp_q[$];
  ex_t  model;
  ex_t  got;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic vld, input logic [31:0] pc,
                              input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                              input logic wr, input logic mr, input logic mw, input logic br,
                              input logic [3:0] op, input logic flush, input logic stall,
                              input logic e_hold, input logic e_iff);
    vec_t v;
    v.vld = vld; v.pc = pc; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd;
    v.wr = wr; v.mr = mr; v.mw = mw; v.br = br; v.op = op;
    v.flush = flush; v.stall = stall; v.e_hold = e_hold; v.e_iff = e_iff;
    return v;
  endfunction

  function automatic ex_t bubble();
    ex_t e;
    e = '0;
    return e;
  endfunction

  // EX expectation: hold on stall, bubble on flush or on a table-declared load-use, else capture.
  function automatic ex_t next_model(input ex_t cur, input vec_t v);
    ex_t e;
    if (v.stall) return cur;
    if (v.flush || v.e_hold || !v.vld) return bubble();
    e.vld = 1'b1; e.pc = v.pc;
    e.d1 = v.pc ^ 32'hA5A5_0000; e.d2 = v.pc ^ 32'h5A5A_0000; e.imm = v.pc + 32'd4;
    e.rs1 = v.rs1; e.rs2 = v.rs2; e.rd = v.rd;
    e.wr = v.wr; e.mr = v.mr; e.mw = v.mw; e.br = v.br; e.op = v.op;
    return e;
  endfunction

  task automatic drive(input vec_t v);
    id_valid = v.vld; id_pc = v.pc;
    id_rs1_data = v.pc ^ 32'hA5A5_0000; id_rs2_data = v.pc ^ 32'h5A5A_0000; id_imm = v.pc + 32'd4;
    id_rs1 = v.rs1; id_use_rs1 = v.u1; id_rs2 = v.rs2; id_use_rs2 = v.u2; id_rd = v.rd;
    id_writeReg = v.wr; id_memRead = v.mr; id_memWrite = v.mw; id_branch = v.br; id_aluOp = v.op;
    ex_flush = v.flush; mem_stall = v.stall;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_ex(input int idx, input ex_t e);
    got = '{vld: ex_valid, pc: ex_pc, d1: ex_rs1_data, d2: ex_rs2_data, imm: ex_imm,
            rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd, wr: ex_writeReg, mr: ex_memRead,
            mw: ex_memWrite, br: ex_branch, op: ex_aluOp};
    chk($sformatf("v%0d ex_valid", idx), 32'(got.vld), 32'(e.vld));
    chk($sformatf("v%0d ex_pc", idx), got.pc, e.pc);
    chk($sformatf("v%0d ex_rs1_data", idx), got.d1, e.d1);
    chk($sformatf("v%0d ex_rs2_data", idx), got.d2, e.d2);
    chk($sformatf("v%0d ex_imm", idx), got.imm, e.imm);
    chk($sformatf("v%0d ex_rs1/rs2/rd", idx), {17'd0, got.rs1, got.rs2, got.rd}, {17'd0, e.rs1, e.rs2, e.rd});
    chk($sformatf("v%0d ex_ctrl", idx), {24'd0, got.wr, got.mr, got.mw, got.br, got.op},
        {24'd0, e.wr, e.mr, e.mw, e.br, e.op});
  endtask

  initial begin
    //        vld pc       rs1 u1 rs2 u2 rd  wr mr mw br op  fl st  hold iff
    tv[0]  = mk(1, 32'h010,  2, 1,  0, 0,  5, 1, 1, 0, 0, 3, 0, 0, 0, 0); // lw x5
    tv[1]  = mk(1, 32'h014,  5, 1,  6, 1,  6, 1, 0, 0, 0, 1, 0, 0, 1, 0); // add uses x5
    tv[2]  = mk(1, 32'h014,  5, 1,  6, 1,  6, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tv[3]  = mk(1, 32'h018,  3, 1,  0, 0,  7, 1, 1, 0, 0, 3, 0, 0, 0, 0); // lw x7
    tv[4]  = mk(1, 32'h01c,  7, 0,  3, 1,  8, 1, 0, 0, 0, 1, 0, 0, 0, 0); // rs1=7 not read
    tv[5]  = mk(1, 32'h020,  2, 1,  0, 0,  0, 0, 1, 0, 0, 3, 0, 0, 0, 0); // lw x0
    tv[6]  = mk(1, 32'h024,  0, 1,  0, 1,  9, 1, 0, 0, 0, 1, 0, 0, 0, 0); // x0 never hazards
    tv[7]  = mk(1, 32'h028,  2, 1,  0, 0,  9, 1, 1, 0, 0, 3, 0, 0, 0, 0); // lw x9
    tv[8]  = mk(1, 32'h02c,  9, 1,  0, 0, 10, 1, 0, 0, 0, 1, 1, 0, 0, 1); // flush beats load-use
    tv[9]  = mk(1, 32'h100,  1, 1,  2, 1, 10, 1, 0, 0, 1, 5, 0, 0, 0, 0); // branch @0x100
    tv[10] = mk(1, 32'h104, 10, 1,  0, 0, 11, 1, 1, 0, 0, 3, 0, 1, 1, 0); // mem stall x3
    tv[11] = mk(1, 32'h108,  0, 0,  0, 0, 12, 1, 0, 1, 0, 2, 1, 1, 1, 0);
    tv[12] = mk(1, 32'h10c,  4, 1,  5, 1, 13, 1, 0, 0, 0, 6, 0, 1, 1, 0);
    tv[13] = mk(0, 32'h110,  3, 1,  4, 1, 13, 1, 1, 1, 1, 7, 0, 0, 0, 0); // invalid ID
    tv[14] = mk(1, 32'h200,  0, 1,  0, 0,  1, 1, 1, 0, 0, 3, 0, 0, 0, 0); // lw x1
    tv[15] = mk(1, 32'h204,  1, 1,  0, 0,  2, 1, 1, 0, 0, 3, 0, 0, 1, 0); // lw x2,0(x1)
    tv[16] = mk(1, 32'h204,  1, 1,  0, 0,  2, 1, 1, 0, 0, 3, 0, 0, 0, 0);
    tv[17] = mk(1, 32'h208,  1, 1,  2, 1,  3, 1, 0, 0, 0, 1, 0, 0, 1, 0); // add x3,x1,x2
    tv[18] = mk(1, 32'h208,  1, 1,  2, 1,  3, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tv[19] = mk(1, 32'h20c,  3, 1,  0, 0,  4, 1, 1, 0, 0, 3, 0, 0, 0, 0); // lw x4
    tv[20] = mk(1, 32'h210,  4, 1,  0, 0,  5, 1, 0, 0, 0, 1, 0, 1, 1, 0); // stall over hazard
    tv[21] = mk(1, 32'h210,  4, 1,  0, 0,  5, 1, 0, 0, 0, 1, 0, 0, 1, 0);
    tv[22] = mk(1, 32'h210,  4, 1,  0, 0,  5, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tv[23] = mk(1, 32'h214,  0, 0,  0, 0, 11, 1, 1, 0, 0, 3, 0, 0, 0, 0); // lw x11
    tv[24] = mk(0, 32'h218, 11, 1,  0, 0, 12, 1, 0, 0, 0, 1, 0, 0, 0, 0); // invalid reader
    tv[25] = mk(1, 32'h21c,  1, 1,  2, 1,  0, 0, 0, 1, 0, 4, 0, 0, 0, 0); // sw

    // Reset state: outputs quiet even with stall/flush requested.
    rst_n = 1'b0;
    drive(tv[9]);
    mem_stall = 1'b1;
    ex_flush  = 1'b1;
    #2;
    model = bubble();
    compare_ex(-1, model);
    chk("reset pc_hold", 32'(pc_hold), 32'd0);
    chk("reset ifid_hold", 32'(ifid_hold), 32'd0);
    chk("reset ifid_flush", 32'(ifid_flush), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_stall = 1'b0;
    ex_flush  = 1'b0;
    id_valid  = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d pc_hold", i), 32'(pc_hold), 32'(tv[i].e_hold));
      chk($sformatf("v%0d ifid_hold", i), 32'(ifid_hold), 32'(tv[i].e_hold));
      chk($sformatf("v%0d ifid_flush", i), 32'(ifid_flush), 32'(tv[i].e_iff));
      exp_q.push_back(next_model(model, tv[i]));
      @(posedge clk);
      #1;
      model = exp_q.pop_front();
      compare_ex(i, model);
    end

`ifdef ID_EX_PERF_EN
    chk("load_use_cnt", load_use_cnt, 32'd4);
    chk("flush_cnt", flush_cnt, 32'd1);
`endif

    // Asynchronous reset while a valid load x7 sits in EX and the pipeline is stalled.
    @(negedge clk);
    drive(mk(1, 32'h300, 0, 0, 0, 0, 7, 1, 1, 0, 0, 3, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("pre-reset ex_valid", 32'(ex_valid), 32'd1);
    chk("pre-reset ex_rd", 32'(ex_rd), 32'd7);
    mem_stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset ex_valid", 32'(ex_valid), 32'd0);
    chk("async reset ex_rd", 32'(ex_rd), 32'd0);
    chk("async reset ex_memRead", 32'(ex_memRead), 32'd0);
    chk("async reset ex_pc", ex_pc, 32'd0);
    chk("async reset pc_hold", 32'(pc_hold), 32'd0);
`ifdef ID_EX_PERF_EN
    chk("async reset load_use_cnt", load_use_cnt, 32'd0);
    chk("async reset flush_cnt", flush_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset stall pc_hold", 32'(pc_hold), 32'd1);
    @(negedge clk);
    drive(mk(1, 32'h304, 7, 1, 0, 0, 3, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    #1;
    chk("post-reset no hazard pc_hold", 32'(pc_hold), 32'd0);
    @(posedge clk);
    #1;
    chk("post-reset ex_valid", 32'(ex_valid), 32'd1);
    chk("post-reset ex_pc", ex_pc, 32'h304);
    chk("post-reset ex_rd", 32'(ex_rd), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: XLEN, default 32, register/PC data width.
REQ-002 Parameter: ALUOP_W, default 4, ALU opcode width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 id_valid  input  1  ID holds a real instruction.
REQ-006 id_pc, id_rs1_data, id_rs2_data, id_imm  input  XLEN each  decoded ID payload.
REQ-007 id_rs1, id_rs2, id_rd  input  5 each  register indices.
REQ-008 id_use_rs1, id_use_rs2  input  1 each  instruction actually reads rs1/rs2.
REQ-009 id_writeReg, id_memRead, id_memWrite, id_branch  input  1 each  decoded control.
REQ-010 id_aluOp  input  ALUOP_W  decoded ALU op.
REQ-011 ex_flush  input  1  branch/jump taken resolved in EX this cycle.
REQ-012 mem_stall  input  1  data memory busy; freeze whole front pipeline.
REQ-013 ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_writeReg, ex_memRead, ex_memWrite, ex_branch, ex_aluOp  output  widths as ID counterparts  registered EX payload; ex_rs1/ex_rs2/ex_rd/ex_writeReg feed the forwarding unit.
REQ-014 pc_hold  output  1  PC must not advance this cycle.
REQ-015 ifid_hold  output  1  IF/ID register must hold this cycle.
REQ-016 ifid_flush  output  1  IF/ID register must load a bubble this cycle.

Function
REQ-017 load_use (combinational) SHALL be 1 iff ex_valid & ex_memRead & ex_rd!=0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-018 Per-edge action priority SHALL be: mem_stall > ex_flush > load_use > advance.
REQ-019 mem_stall=1: all EX registers SHALL hold; pc_hold=ifid_hold=1; ifid_flush=0.
REQ-020 ex_flush=1 (no mem_stall): EX SHALL load a bubble; ifid_flush=1; pc_hold=ifid_hold=0; load_use ignored.
REQ-021 load_use=1 (no mem_stall/flush): EX SHALL load a bubble; pc_hold=ifid_hold=1; ifid_flush=0.
REQ-022 Advance: EX registers SHALL capture all id_* fields (ex_valid<=id_valid); holds/flush all 0.
REQ-023 Bubble SHALL set ex_valid, ex_writeReg, ex_memRead, ex_memWrite, ex_branch, ex_rd, ex_rs1, ex_rs2, ex_aluOp to 0; data fields to 0.
REQ-024 id_valid=0 on advance SHALL load a bubble (control fields forced 0 regardless of id_* control).
REQ-025 Load-use stall SHALL last exactly one cycle per hazard (bubble clears ex_memRead); back-to-back loads each stall independently.
REQ-026 pc_hold, ifid_hold, ifid_flush SHALL be combinational from current inputs and EX state; latency ID->EX exactly 1 cycle.

Reset
REQ-027 rst_n low SHALL immediately force all EX registers to bubble values (REQ-023) and all counters to 0, independent of clk.
REQ-028 Outputs during reset: pc_hold=ifid_hold=ifid_flush=0; first edge after deassert SHALL follow REQ-018.
REQ-029 Reset mid-stall SHALL discard the stall; no state survives.

Configuration
REQ-030 Macro ID_EX_PERF_EN defined: adds outputs load_use_cnt and flush_cnt (32 bits each), incrementing once per edge on which REQ-021 / REQ-020 action is taken; wrap at 2^32.
REQ-031 Macro undefined: counter ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-032 Shared package pipe_pkg SHALL hold XLEN, ALUOP_W, register-index width (5) and bubble field constants.
REQ-033 Sub-module hazard_detect SHALL implement REQ-017 combinationally; id_ex_stage instantiates it once.

Verification
REQ-034 lw x5 in EX (ex_memRead=1, ex_rd=5), ID add rs1=5 use_rs1=1 -> pc_hold=ifid_hold=1 one cycle, next ex_valid=0, following cycle add enters EX.
REQ-035 Same as REQ-034 but id_use_rs1=0 (rs1 field=5) or ex_rd=0 -> no stall, add advances.
REQ-036 load_use=1 and ex_flush=1 same cycle -> ifid_flush=1, pc_hold=0, EX bubble; load_use_cnt unchanged, flush_cnt+1 (PERF_EN).
REQ-037 mem_stall=1 for 3 cycles with ex_pc=0x100 -> ex_pc stays 0x100, pc_hold=ifid_hold=1 all 3 cycles; ex_flush during stall ignored.
REQ-038 rst_n low asynchronously while ex_valid=1, ex_rd=7 -> ex_valid=0, ex_rd=0 before next clk edge; counters 0.
REQ-039 Two consecutive lw x1; lw x2,0(x1); add x3,x2 -> two separate one-cycle stalls, load_use_cnt=2.
